// File: rtl/core_mem_arbiter_if.sv
// Bundle of core-side request/response and memory-port signals for the shared data memory arbiter.
// The slave modport is the arbiter's view; master is the cores-plus-memory side.
interface core_mem_arbiter_if #(
    parameter int CORE_COUNT = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic [CORE_COUNT-1:0]            core_req;
    logic [CORE_COUNT-1:0]            core_we;
    logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr;
    logic [CORE_COUNT*DATA_WIDTH-1:0] core_wdata;
    logic [CORE_COUNT-1:0]            core_gnt;
    logic [CORE_COUNT-1:0]            core_rvalid;
    logic [DATA_WIDTH-1:0]            core_rdata;
    logic                             mem_en;
    logic                             mem_we;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH-1:0]            mem_wdata;
    logic [DATA_WIDTH-1:0]            mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_gnt, core_rvalid, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between CORE_COUNT cores.
// Each access is one ACCESS cycle; reads then wait MEM_LATENCY cycles for the memory data.
module core_mem_arbiter #(
    parameter int CORE_COUNT  = 2,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    core_mem_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int IDX_W = $clog2(CORE_COUNT);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] winner, winner_next;
    logic [IDX_W-1:0] last_grant, last_grant_next;
    logic [CNT_W-1:0] count, count_next;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;

    // First requester strictly after last_grant, wrapping modulo CORE_COUNT.
    always_comb begin
        rr_pick  = last_grant;
        rr_idx   = last_grant;
        rr_found = 1'b0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            rr_idx = (rr_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : rr_idx + 1'b1;
            if (!rr_found && bus.core_req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            winner     <= '0;
            last_grant <= IDX_W'(CORE_COUNT - 1);
            count      <= '0;
        end else begin
            state      <= state_next;
            winner     <= winner_next;
            last_grant <= last_grant_next;
            count      <= count_next;
        end
    end

    // Outputs are forced to zero while rst is high, even before the state register has cleared.
    always_comb begin
        state_next      = state;
        winner_next     = winner;
        last_grant_next = last_grant;
        count_next      = count;
        bus.core_gnt    = '0;
        bus.core_rvalid = '0;
        bus.core_rdata  = '0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        busy            = 1'b0;

        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (|bus.core_req) begin
                        winner_next = rr_pick;
                        state_next  = ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_en           = 1'b1;
                    bus.mem_we           = bus.core_we[winner];
                    bus.mem_addr         = bus.core_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.mem_wdata        = bus.core_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    bus.core_gnt[winner] = 1'b1;
                    last_grant_next      = winner;
                    if (bus.core_we[winner]) begin
                        state_next = IDLE;
                    end else begin
                        count_next = CNT_W'(MEM_LATENCY - 1);
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        bus.core_rvalid[winner] = 1'b1;
                        bus.core_rdata          = bus.mem_rdata;
                        state_next              = IDLE;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule
